// File: rtl/hd_timing_gen.sv
// hd_timing_gen: 720p raster timing generator for the PAL-to-HD path.
// Pixel strobe, syncs, de, coordinates; optional frame lock to i_frame_end.
//
// Ports:
//   clk          system clock (shared with the upsampler)
//   rst_n        asynchronous reset, active low
//   i_frame_end  one-clk pulse from the upsampler's o_frame_end
//   o_hd_clk     pixel clock strobe, 50% duty, period 2*HALF_DIV clk
//   o_hd_hsync   active-high hsync
//   o_hd_vsync   active-high vsync
//   o_hd_de      high inside the active area
//   o_hd_x       current pixel column, zero-extended
//   o_hd_y       current line, zero-extended
//   o_line_start one-clk pulse when the column wraps to 0
//   o_locked     frame lock achieved
//
// Build option: define HD_TIMING_FRAME_LOCK_EN to enable the frame-lock
// FSM (FREE -> WAIT -> LOCKED). Without it the raster always free-runs
// and o_locked is tied low.
module hd_timing_gen #(
  parameter int HALF_DIV     = 2,
  parameter int H_ACTIVE     = 1280,
  parameter int H_FP         = 110,
  parameter int H_SYNC       = 40,
  parameter int H_BP         = 220,
  parameter int V_ACTIVE     = 720,
  parameter int V_FP         = 5,
  parameter int V_SYNC       = 5,
  parameter int V_BP         = 20,
  parameter int LOCK_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_frame_end,
  output logic        o_hd_clk,
  output logic        o_hd_hsync,
  output logic        o_hd_vsync,
  output logic        o_hd_de,
  output logic [10:0] o_hd_x,
  output logic [9:0]  o_hd_y,
  output logic        o_line_start,
  output logic        o_locked
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int DW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  localparam logic [DW-1:0] HC_LAST = DW'(HALF_DIV - 1);
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] r_hc;
  logic          r_hd_clk;
  logic [HW-1:0] r_h;
  logic [HW-1:0] w_h_nxt;
  logic [VW-1:0] r_v;
  logic [VW-1:0] w_v_nxt;
  logic          r_first;

  logic w_hc_wrap;
  logic w_tick;
  logic w_h_last;
  logic w_v_last;
  logic w_hold;
  logic w_step;
  logic w_line_start;
  logic w_hs;
  logic w_vs;
  logic w_de;

  assign w_hc_wrap = (r_hc == HC_LAST);
  // pixel tick on the 1->0 toggle of the strobe
  assign w_tick    = w_hc_wrap & r_hd_clk;
  assign w_h_last  = (r_h == H_LAST);
  assign w_v_last  = (r_v == V_LAST);
  assign w_step    = w_tick & ~w_hold;
  assign w_line_start = w_step & w_h_last;

  always_comb begin
    w_h_nxt = r_h;
    w_v_nxt = r_v;
    if (w_step) begin
      if (w_h_last) begin
        w_h_nxt = '0;
        w_v_nxt = w_v_last ? '0 : r_v + VW'(1);
      end else begin
        w_h_nxt = r_h + HW'(1);
      end
    end
  end

  // decode from next-state counters so syncs/de line up with x/y
  assign w_hs = (w_h_nxt >= HS_BEG) && (w_h_nxt < HS_END);
  assign w_vs = (w_v_nxt >= VS_BEG) && (w_v_nxt < VS_END);
  assign w_de = (w_h_nxt < H_ACT) && (w_v_nxt < V_ACT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hc         <= '0;
      r_hd_clk     <= 1'b0;
      r_h          <= '0;
      r_v          <= '0;
      r_first      <= 1'b1;
      o_hd_hsync   <= 1'b0;
      o_hd_vsync   <= 1'b0;
      o_hd_de      <= 1'b0;
      o_line_start <= 1'b0;
    end else begin
      r_hc <= w_hc_wrap ? '0 : r_hc + DW'(1);
      if (w_hc_wrap) begin
        r_hd_clk <= ~r_hd_clk;
      end
      r_h          <= w_h_nxt;
      r_v          <= w_v_nxt;
      r_first      <= 1'b0;
      o_hd_hsync   <= w_hs;
      o_hd_vsync   <= w_vs;
      o_hd_de      <= w_de;
      // r_first flags the first line after reset release
      o_line_start <= w_line_start | r_first;
    end
  end

  assign o_hd_clk = r_hd_clk;
  assign o_hd_x   = 11'(r_h);
  assign o_hd_y   = 10'(r_v);

`ifdef HD_TIMING_FRAME_LOCK_EN
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(LOCK_TIMEOUT);

  typedef enum logic [1:0] {
    S_FREE,
    S_WAIT,
    S_LOCKED
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_fe_seen;
  logic          r_locked;
  logic [TW-1:0] r_to;
  logic [TW-1:0] w_to_nxt;
  logic          w_fe;
  logic          w_frame_end;
  logic          w_fe_clr;
  logic          w_lock_set;
  logic          w_lock_clr;

  // a pulse arriving on the frame-end clk still counts as seen
  assign w_fe        = r_fe_seen | i_frame_end;
  assign w_frame_end = w_tick & w_h_last & w_v_last;

  always_comb begin
    w_state_nxt = r_state;
    w_to_nxt    = r_to;
    w_hold      = 1'b0;
    w_fe_clr    = 1'b0;
    w_lock_set  = 1'b0;
    w_lock_clr  = 1'b0;
    unique case (r_state)
      S_FREE: begin
        if (w_fe) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT, S_LOCKED: begin
        if (w_frame_end) begin
          if (w_fe) begin
            w_state_nxt = S_LOCKED;
            w_fe_clr    = 1'b1;
            w_lock_set  = 1'b1;
            w_to_nxt    = '0;
          end else if (r_to == TO_MAX) begin
            w_state_nxt = S_FREE;
            w_lock_clr  = 1'b1;
            w_to_nxt    = '0;
          end else begin
            // park on the last pixel until the source frame ends
            w_hold   = 1'b1;
            w_to_nxt = r_to + TW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_FREE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FREE;
      r_fe_seen <= 1'b0;
      r_locked  <= 1'b0;
      r_to      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_to      <= w_to_nxt;
      // set wins over a same-clk clear
      r_fe_seen <= i_frame_end | (r_fe_seen & ~w_fe_clr);
      if (w_lock_set) begin
        r_locked <= 1'b1;
      end else if (w_lock_clr) begin
        r_locked <= 1'b0;
      end
    end
  end

  assign o_locked = r_locked;
`else
  logic w_unused;
  assign w_unused = i_frame_end;
  assign w_hold   = 1'b0;
  assign o_locked = 1'b0;
`endif

endmodule
